multicycle_control: RTL and testbench

Multi-cycle sequencing controller for the MIPS core: a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. It replaces the single-cycle combinational decoder when the datapath shares one memory port and one ALU across cycles. It drives every datapath mux select and write enable, and it stalls on a memory-ready handshake.

---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Interface between the multi-cycle controller and the MIPS datapath.
// The controller is the master; the datapath (or a bench) sits on the slave side.
interface multicycle_control_if;
  logic [5:0] OpCode;
  logic       mem_ready;
  logic       PCWrite;
  logic       Branch;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  OpCode, mem_ready,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, done,
           illegal_op, state
  );

  modport slave (
    output OpCode, mem_ready,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, done,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multi-cycle MIPS core (fetch/decode/execute/mem/wb).
// Define MC_JUMP_EN to build the JUMP state; otherwise opcode 000010 is illegal.
module multicycle_control (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIWB = 4'd10
`ifdef MC_JUMP_EN
    ,
    JUMP   = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  state_t cur_state;
  state_t nxt_state;

  always_ff @(posedge clk) begin
    if (!reset) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  assign bus.state = cur_state;

  // Unused encodings fall into the default arm: outputs stay 0 and we resync at FETCH.
  always_comb begin
    nxt_state      = FETCH;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemToReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.PCSrc      = 2'b00;
    bus.done       = 1'b0;
    bus.illegal_op = 1'b0;

    case (cur_state)
      IDLE: nxt_state = FETCH;

      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        nxt_state   = bus.mem_ready ? DECODE : FETCH;
      end

      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.OpCode)
          OP_RTYPE:              nxt_state = EXEC;
          OP_LW, OP_SW, OP_ADDI: nxt_state = MEMADR;
          OP_BEQ:                nxt_state = BRANCH;
`ifdef MC_JUMP_EN
          OP_J:                  nxt_state = JUMP;
`endif
          default: begin
            bus.illegal_op = 1'b1;
            bus.done       = 1'b1;
            nxt_state      = FETCH;
          end
        endcase
      end

      // The IR holds the opcode from FETCH onward, so it can be re-decoded here.
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (bus.OpCode)
          OP_LW:   nxt_state = MEMRD;
          OP_SW:   nxt_state = MEMWR;
          OP_ADDI: nxt_state = ADDIWB;
          default: nxt_state = FETCH;
        endcase
      end

      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        nxt_state   = bus.mem_ready ? MEMWB : MEMRD;
      end

      MEMWB: begin
        bus.MemToReg = 1'b1;
        bus.RegWrite = 1'b1;
        bus.done     = 1'b1;
      end

      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        bus.done     = bus.mem_ready;
        nxt_state    = bus.mem_ready ? FETCH : MEMWR;
      end

      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        nxt_state   = ALUWB;
      end

      ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        bus.done     = 1'b1;
      end

      BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b01;
        bus.PCSrc   = 2'b01;
        bus.Branch  = 1'b1;
        bus.done    = 1'b1;
      end

      ADDIWB: begin
        bus.RegWrite = 1'b1;
        bus.done     = 1'b1;
      end

`ifdef MC_JUMP_EN
      JUMP: begin
        bus.PCWrite = 1'b1;
        bus.PCSrc   = 2'b10;
        bus.done    = 1'b1;
      end
`endif

      default: nxt_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks lw, sw, R-type, beq, addi, j and
// an illegal opcode through the FSM, including memory stalls and a mid-instruction reset.
module tb_multicycle_control;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control word: PCWrite Branch IorD MemRead MemWrite IRWrite RegDst
  // MemToReg RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSrc[2] done illegal_op
  logic [17:0] ctlObs;
  assign ctlObs = {bus.PCWrite, bus.Branch, bus.IorD, bus.MemRead, bus.MemWrite,
                   bus.IRWrite, bus.RegDst, bus.MemToReg, bus.RegWrite, bus.ALUSrcA,
                   bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.done, bus.illegal_op};

  localparam logic [17:0] C_ZERO   = 18'b0;
  localparam logic [17:0] C_FRDY   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FWAIT  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_DECILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
  localparam logic [17:0] C_MADR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MRD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MWB    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] C_MWWAIT = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MWRDY  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] C_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_ALUWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_BR     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] C_ADDIWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
`ifdef MC_JUMP_EN
  localparam logic [17:0] C_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic rdy);
    bus.OpCode    = op;
    bus.mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expState,
                             input logic [17:0] expCtl);
    compared++;
    assert (bus.state === expState) else begin
      mismatched++;
      $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, bus.state, expState);
    end
    compared++;
    assert (ctlObs === expCtl) else begin
      mismatched++;
      $error("[TB] FAIL %s ctl observed=%b expected=%b", tag, ctlObs, expCtl);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    applyStimulus(6'b000000, 1'b1);

    tick(); tick();
    checkOutput("reset_idle", 4'd0, C_ZERO);
    reset = 1'b1;
    #1;
    checkOutput("release_idle", 4'd0, C_ZERO);
    tick();

    // lw: 5 cycles, single done in MEMWB
    applyStimulus(6'b100011, 1'b1);
    checkOutput("lw_fetch", 4'd1, C_FRDY);   tick();
    checkOutput("lw_decode", 4'd2, C_DEC);   tick();
    checkOutput("lw_memadr", 4'd3, C_MADR);  tick();
    checkOutput("lw_memrd", 4'd4, C_MRD);    tick();
    checkOutput("lw_memwb", 4'd5, C_MWB);    tick();

    // sw with two wait cycles in MEMWR
    applyStimulus(6'b101011, 1'b1);
    checkOutput("sw_fetch", 4'd1, C_FRDY);   tick();
    checkOutput("sw_decode", 4'd2, C_DEC);   tick();
    checkOutput("sw_memadr", 4'd3, C_MADR);  tick();
    applyStimulus(6'b101011, 1'b0);
    checkOutput("sw_wait1", 4'd6, C_MWWAIT); tick();
    checkOutput("sw_wait2", 4'd6, C_MWWAIT); tick();
    applyStimulus(6'b101011, 1'b1);
    checkOutput("sw_ready", 4'd6, C_MWRDY);  tick();

    // R-type then beq
    applyStimulus(6'b000000, 1'b1);
    checkOutput("r_fetch", 4'd1, C_FRDY);    tick();
    checkOutput("r_decode", 4'd2, C_DEC);    tick();
    checkOutput("r_exec", 4'd7, C_EXEC);     tick();
    checkOutput("r_aluwb", 4'd8, C_ALUWB);   tick();
    applyStimulus(6'b000100, 1'b1);
    checkOutput("beq_fetch", 4'd1, C_FRDY);  tick();
    checkOutput("beq_decode", 4'd2, C_DEC);  tick();
    checkOutput("beq_branch", 4'd9, C_BR);   tick();

    // addi with a 4-cycle stall in FETCH
    applyStimulus(6'b001000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fetch_wait%0d", i), 4'd1, C_FWAIT);
      tick();
    end
    applyStimulus(6'b001000, 1'b1);
    checkOutput("addi_fetch", 4'd1, C_FRDY);   tick();
    checkOutput("addi_decode", 4'd2, C_DEC);   tick();
    checkOutput("addi_memadr", 4'd3, C_MADR);  tick();
    checkOutput("addi_wb", 4'd10, C_ADDIWB);   tick();

    // j opcode: JUMP when built, illegal otherwise
    applyStimulus(6'b000010, 1'b1);
    checkOutput("j_fetch", 4'd1, C_FRDY);    tick();
`ifdef MC_JUMP_EN
    checkOutput("j_decode", 4'd2, C_DEC);    tick();
    checkOutput("j_jump", 4'd11, C_JUMP);    tick();
`else
    checkOutput("j_illegal", 4'd2, C_DECILL); tick();
`endif

    // unsupported opcode
    applyStimulus(6'b111111, 1'b1);
    checkOutput("ill_fetch", 4'd1, C_FRDY);    tick();
    checkOutput("ill_decode", 4'd2, C_DECILL); tick();

    // reset asserted while sw stalls in MEMWR
    applyStimulus(6'b101011, 1'b1);
    checkOutput("rst_fetch", 4'd1, C_FRDY);  tick();
    tick(); tick();
    applyStimulus(6'b101011, 1'b0);
    checkOutput("rst_memwr", 4'd6, C_MWWAIT);
    reset = 1'b0;
    #1;
    checkOutput("rst_pre_edge", 4'd6, C_MWWAIT);
    tick();
    checkOutput("rst_cycle1", 4'd0, C_ZERO);  tick();
    checkOutput("rst_cycle2", 4'd0, C_ZERO);  tick();
    checkOutput("rst_cycle3", 4'd0, C_ZERO);
    reset = 1'b1;
    tick();
    checkOutput("rst_refetch", 4'd1, C_FWAIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
